hack_mem_io: RTL
================

Name: hack_mem_io

Overview:
- Data-memory and memory-mapped I/O stage directly downstream of hack_no_ram.
- Consumes the CPU's addressM/outM/writeM and returns inM in the same cycle.
- Holds the data RAM, a keyboard keycode FIFO fed by an upstream key decoder, and a free-running tick counter.
- hack_no_ram plus hack_mem_io plus an instruction ROM form the full Hack system.

Parameters:
- RAM_DEPTH, 16384: data RAM words, mapped at 0x0000..RAM_DEPTH-1; must be ≤ 16384 and a power of 2.
- FIFO_DEPTH, 8: keycode FIFO entries; power of 2, ≥ 2.
- TICK_DIV, 1000: clk cycles per tick-counter increment; ≥ 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- addressM  input  15  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe, sampled on clk rising edge.
- inM  output  16  read data for addressM, combinational.
- key_code  input  16  keycode from upstream decoder.
- key_valid  input  1  key_code valid.
- key_ready  output  1  FIFO accepts key_code this cycle.

Behaviour:
- Address map; all reads are combinational from addressM, with no latency:
  - 0x0000..RAM_DEPTH-1: RAM. Read returns the stored word. Write stores outM at the clk edge when writeM=1.
  - 0x6000 KBD: read returns the FIFO head, or 0x0000 when empty. A write (any data) pops one entry; a pop when empty is ignored.
  - 0x6001 KBD_STAT: read bit0 = not empty, bit1 = full, bit2 = overflow (sticky), bits[7:4] = entry count (saturates at 15), other bits 0. A write (any data) clears overflow.
  - 0x6002 TICK: read returns the tick counter. A write loads the counter with outM and clears the prescaler.
  - All other addresses, including 0x4000..0x5FFF: read 0x0000, write ignored, no side effects.
- Read during write to the same RAM address: inM shows the old word in that cycle and the new word from the next cycle.
- Keycode FIFO:
  - Push when key_valid && key_ready.
  - key_ready = !full, combinational from the count.
  - key_valid while full sets overflow; key_code is dropped.
  - Push and pop in the same cycle when non-empty: both happen, count unchanged, FIFO order preserved.
  - Push and pop in the same cycle when empty: push only (pop ignored).
  - Pop while full frees one entry; key_ready rises the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Tick counter:
  - Prescaler counts 0..TICK_DIV-1. When it reaches TICK_DIV-1 it returns to 0 and the counter increments.
  - The counter wraps 0xFFFF→0x0000.
  - A CPU write to 0x6002 takes priority over an increment in the same cycle.
- Reset:
  - FIFO emptied, overflow=0, tick=0, prescaler=0, key_ready=1 the cycle after reset.
  - RAM contents are not cleared.
  - Reset mid-operation discards FIFO contents and pending pops.
  - CPU writes are ignored while reset=1.
  - With reset=1 and addressM in RAM range, inM still returns RAM contents; other registers read their reset values.

Optional Feature:
- HACK_MEM_IO_TICK_EN
- Defined: tick counter and prescaler present at 0x6002 as above.
- Undefined: no counter or prescaler logic is built; 0x6002 reads 0x0000 and writes are ignored; TICK_DIV is unused.

Test Plan:
- RAM write/read:
  - Stimulus: addressM=0x0005, outM=0x1234, writeM=1 for one cycle.
  - Required: inM=0x1234 from the next cycle.
  - Stimulus: addressM=0x3FFF written with 0xBEEF.
  - Required: 0x3FFF reads 0xBEEF; 0x0005 still reads 0x1234.
- Unmapped:
  - Stimulus: write 0xFFFF to 0x4000 and 0x7FFF.
  - Required: both read 0x0000; RAM 0x0000 unchanged.
- FIFO fill and drain:
  - Stimulus: push 0x0041..0x0048 (8 keys); then key_valid with 0x0049.
  - Required: after 8 pushes key_ready=0 and KBD_STAT=0x0083; the 0x0049 attempt sets overflow, so KBD_STAT=0x0087.
  - Stimulus: 8 writes to 0x6000.
  - Required: KBD reads 0x0041..0x0048 in order, then 0x0000, with KBD_STAT=0x0004 after the last pop.
  - Stimulus: write 0x6001.
  - Required: KBD_STAT=0x0000.
- Simultaneous push/pop:
  - Stimulus: with 1 entry (0x0061), push 0x0062 and pop 0x6000 in the same cycle.
  - Required: count stays 1; KBD reads 0x0062.
- Tick (TICK_DIV=4, macro defined):
  - Stimulus: run 12 cycles after reset.
  - Required: TICK reads 0x0003.
  - Stimulus: write 0xFFFF to 0x6002, run 4 more cycles.
  - Required: TICK reads 0x0000.
  - Macro undefined: TICK always reads 0x0000.
- Reset mid-operation:
  - Stimulus: with 3 FIFO entries, overflow=1 and tick=0x0010, assert reset for 1 cycle.
  - Required: KBD_STAT=0x0000, TICK=0x0000, key_ready=1; a previously written RAM word is still readable.

Source files
------------

// File: rtl/hack_mem_io.sv
// Hack data memory plus memory-mapped keyboard FIFO and tick counter.
// Optional tick counter at 0x6002 is built only when HACK_MEM_IO_TICK_EN is defined.
module hack_mem_io #(
  parameter int RAM_DEPTH  = 16384,
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic        key_ready
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = PW + 1;

  localparam logic [15:0] RAM_LIMIT = 16'(RAM_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [14:0] ADDR_KBD  = 15'h6000;
  localparam logic [14:0] ADDR_STAT = 15'h6001;
  localparam logic [14:0] ADDR_TICK = 15'h6002;

  // Entry count shown in KBD_STAT is a 4-bit field that clamps at 15.
  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    if (32'(c) > 32'd15) return 4'hF;
    else                 return 4'(c);
  endfunction

  logic [15:0]        ram [RAM_DEPTH];
  logic [15:0]        fifo_mem [FIFO_DEPTH];

  logic               in_ram;
  logic [RAM_AW-1:0]  ram_idx;
  logic               cpu_wr;
  logic               ram_we;
  logic               kbd_wr;
  logic               stat_wr;
  logic               tick_wr;

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [15:0]        fifo_head;
  logic [15:0]        stat_word;
  logic [15:0]        tick;

  // Address decode; CPU writes are suppressed while reset is held.
  assign in_ram  = ({1'b0, addressM} < RAM_LIMIT);
  assign ram_idx = addressM[RAM_AW-1:0];
  assign cpu_wr  = writeM && !reset;
  assign ram_we  = cpu_wr && in_ram;
  assign kbd_wr  = cpu_wr && (addressM == ADDR_KBD);
  assign stat_wr = cpu_wr && (addressM == ADDR_STAT);
  assign tick_wr = cpu_wr && (addressM == ADDR_TICK);

  // RAM contents are never reset; a write lands at the edge, so a
  // same-cycle read of that address still sees the old word.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= outM;
  end

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign key_ready = !full;
  assign push      = key_valid && !full && !reset;
  assign pop       = kbd_wr && !empty;
  assign fifo_head = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped key in the same cycle as a clear wins, so no drop goes unseen.
  always_ff @(posedge clk) begin
    if (reset)                 overflow <= 1'b0;
    else if (key_valid && full) overflow <= 1'b1;
    else if (stat_wr)          overflow <= 1'b0;
  end

  assign stat_word = {8'h00, sat_count(count), 1'b0, overflow, full, !empty};

`ifdef HACK_MEM_IO_TICK_EN
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSW-1:0] PRE_LAST = PSW'(TICK_DIV - 1);

  logic [PSW-1:0] prescale;
  logic [15:0]    tick_cnt;

  // A CPU load beats a same-cycle increment and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      tick_cnt <= '0;
    end else if (tick_wr) begin
      prescale <= '0;
      tick_cnt <= outM;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      tick_cnt <= tick_cnt + 16'd1;
    end else begin
      prescale <= prescale + PSW'(1);
    end
  end

  assign tick = tick_cnt;
`else
  localparam int unused_tick_div = TICK_DIV;
  logic unused_tick_wr;

  assign unused_tick_wr = tick_wr;
  assign tick           = 16'h0000;
`endif

  // Read mux: RAM stays visible during reset, registers read as their reset values.
  always_comb begin
    inM = 16'h0000;
    if (in_ram) begin
      inM = ram[ram_idx];
    end else if (!reset) begin
      case (addressM)
        ADDR_KBD:  inM = empty ? 16'h0000 : fifo_head;
        ADDR_STAT: inM = stat_word;
        ADDR_TICK: inM = tick;
        default:   inM = 16'h0000;
      endcase
    end
  end

endmodule
